vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Pixel-clock VGA timing source: the producer side of the pix_x/pix_y -> color interface that every flag_* renderer consumes.
//  Runs horizontal/vertical counters, drives pix_x/pix_y to the selected flag, then registers the returned 6-bit color.
//  Blanks the registered color outside the active area and packs it with delay-matched sync onto the TinyVGA PMOD byte.
//  Also provides frame/line strobes and a frame counter for animated flags.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (clocks)
//  H_SYNC    96   hsync pulse width (clocks)
//  H_BP      48   horizontal back porch (clocks)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
//  SYNC_POL  0    sync active level; 0 = active-low (640x480@60)
// PORTS
//  clk         in   1   pixel clock, 25.175 MHz nominal
//  reset       in   1   synchronous, active-high reset
//  color_in    in   6   flag color {R1,R0,G1,G0,B1,B0}, combinational from pix_x/pix_y
//  pix_x       out  10  current horizontal count (0..799), to flag
//  pix_y       out  10  current vertical count (0..524), to flag
//  display_on  out  1   pix_x<H_ACTIVE && pix_y<V_ACTIVE (same cycle as pix_x/pix_y)
//  line_start  out  1   1-cycle pulse when pix_x==0
//  frame_start out  1   1-cycle pulse when pix_x==0 && pix_y==0
//  frame_cnt   out  8   frame counter, increments on each line-524 -> line-0 wrap, mod 256
//  vga_out     out  8   registered {hsync,B0,G0,R0,vsync,B1,G1,R1} (TinyVGA PMOD order)
// BEHAVIOUR
//  - Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL=800), +1 every clk; at H_TOTAL-1 wrap to 0 and v_cnt +1.
//    v_cnt 0..V_TOTAL-1 (V_TOTAL=525); when h and v are both at max, both wrap to 0 and frame_cnt +1.
//  - pix_x/pix_y are the counter registers directly, with no decoding. Flags see stable coordinates for a full clock.
//  - Stage-0 syncs: hs0 = (h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]) = [656,751].
//    vs0 = (v_cnt in [490,491]). Active = SYNC_POL.
//  - Stage 1, single register, latency 1 clk from coordinate to vga_out:
//    color_q = display_on ? color_in : 6'b0; hs_q/vs_q = hs0/vs0 at stage-0 timing.
//    vga_out is built only from these regs, with no combinational path from color_in to vga_out.
//  - Reset (sync): h_cnt=0, v_cnt=0, frame_cnt=0, color_q=0.
//    hs_q/vs_q = inactive (1 when SYNC_POL=0), so vga_out = 8'b1000_1000 for SYNC_POL=0.
//  - Reset asserted mid-line/mid-frame: the next clk returns all state to reset values.
//    The first post-reset cycle presents pix_x=0,pix_y=0 with frame_start=1.
//  - line_start/frame_start/display_on are combinational decodes of the counters and are glitch-free relative to clk.
//  - frame_cnt wraps 255 -> 0 silently. Counter widths: 10 bits each; all comparisons are unsigned on 10 bits.
//  - Parameter sums must fit 10 bits (H_TOTAL, V_TOTAL <= 1024); this is checked by an elaboration-time guard.
// STRUCTURE
//  - Shared include vga_timing.vh: the 640x480@60 default timing constants, SYNC_POL default, and the PMOD bit-position
//    constants. Color macros stay in flag.vh.
//  - One natural sub-module: vga_sync_counter (h/v counters, wrap, frame_cnt, stage-0 sync/active decode).
//    The top level adds the color/sync output register and PMOD packing.
// TESTING
//  1. Reset held 3 clks, then released.
//     -> vga_out==8'h88 during reset; first cycle after reset: pix_x=0, pix_y=0, frame_start=1, display_on=1.
//  2. Free-run 1 line.
//     -> line_start period 800 clks; vga_out[7] low exactly for the clk after pix_x=656 through the clk after pix_x=751 (96 clks).
//  3. Free-run 1 frame.
//     -> frame_start period 420000 clks; vga_out[3] low for 1600 clks, starting 1 clk after pix_y=490,pix_x=0; frame_cnt +1.
//  4. color_in forced 6'b111111.
//     -> color bits of vga_out all 1 only on the 307200 cycles following display_on=1, 0 at pix_x=640..799 and pix_y>=480.
//  5. color_in = 6'b10_01_11 at pix_x=5.
//     -> next clk vga_out = {1,1,1,0,1,1,0,1}, i.e. R1=1,R0=0,G1=0,G0=1,B1=1,B0=1, syncs inactive.
//  6. Reset pulsed at pix_x=300, pix_y=200; separately run 256 frames.
//     -> post-reset counters restart at 0,0 with frame_cnt=0; after 256 frames frame_cnt wraps back to 0.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared timing defaults, colour/PMOD bit positions and the output packing helper
// for the VGA timing source and its counter sub-module.
package vga_timing_gen_pkg;

    // 640x480@60 defaults (25.175 MHz pixel clock)
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam bit SYNC_POL_DEF = 1'b0;

    localparam int CNT_W   = 10;
    localparam int CNT_MAX = 1 << CNT_W;

    // Bit positions inside color_in {R1,R0,G1,G0,B1,B0}
    localparam int COL_R1 = 5;
    localparam int COL_R0 = 4;
    localparam int COL_G1 = 3;
    localparam int COL_G0 = 2;
    localparam int COL_B1 = 1;
    localparam int COL_B0 = 0;

    // Bit positions on the TinyVGA PMOD byte
    localparam int PMOD_HSYNC = 7;
    localparam int PMOD_B0    = 6;
    localparam int PMOD_G0    = 5;
    localparam int PMOD_R0    = 4;
    localparam int PMOD_VSYNC = 3;
    localparam int PMOD_B1    = 2;
    localparam int PMOD_G1    = 1;
    localparam int PMOD_R1    = 0;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [5:0] color;
    } pix_out_t;

    function automatic logic [7:0] pack_pmod(input pix_out_t p);
        logic [7:0] b;
        b             = 8'h00;
        b[PMOD_HSYNC] = p.hs;
        b[PMOD_VSYNC] = p.vs;
        b[PMOD_R1]    = p.color[COL_R1];
        b[PMOD_R0]    = p.color[COL_R0];
        b[PMOD_G1]    = p.color[COL_G1];
        b[PMOD_G0]    = p.color[COL_G0];
        b[PMOD_B1]    = p.color[COL_B1];
        b[PMOD_B0]    = p.color[COL_B0];
        return b;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_counter.sv
// Horizontal/vertical raster counters with frame counter, plus stage-0 decodes of
// the active area, line/frame strobes and sync windows.
module vga_sync_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = SYNC_POL_DEF
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic [7:0] frame_cnt,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic       hs0,
    output logic       vs0
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Every timing sum has to be representable in the 10-bit counters.
    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_timing_too_large
        $error("vga_sync_counter: H_TOTAL/V_TOTAL exceed 10-bit counter range");
    end

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
        end else if (h_cnt == H_MAX) begin
            h_cnt <= '0;
            if (v_cnt == V_MAX) begin
                v_cnt     <= '0;
                frame_cnt <= frame_cnt + 8'd1;
            end else begin
                v_cnt <= v_cnt + 10'd1;
            end
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Pure decodes of registered counters, so they settle once per clock.
    always_comb begin
        display_on  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        line_start  = (h_cnt == 10'd0);
        frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
        hs0         = ((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vs0         = ((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source: drives pix_x/pix_y to a flag renderer, registers the returned
// colour (blanked outside the active area) together with sync onto the PMOD byte.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = SYNC_POL_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] color_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt,
    output logic [7:0] vga_out
);

    logic     hs0;
    logic     vs0;
    pix_out_t out_q;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_counter (
        .clk         (clk),
        .reset       (reset),
        .h_cnt       (pix_x),
        .v_cnt       (pix_y),
        .frame_cnt   (frame_cnt),
        .display_on  (display_on),
        .line_start  (line_start),
        .frame_start (frame_start),
        .hs0         (hs0),
        .vs0         (vs0)
    );

    // One register stage keeps colour and sync aligned; colour_in never reaches
    // the pins combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q.hs    <= ~SYNC_POL;
            out_q.vs    <= ~SYNC_POL;
            out_q.color <= '0;
        end else begin
            out_q.hs    <= hs0;
            out_q.vs    <= vs0;
            out_q.color <= display_on ? color_in : 6'b0;
        end
    end

    assign vga_out = pack_pmod(out_q);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a 640x480 instance for line-level timing and a
// tiny-raster instance (active-high sync) for frame-level timing and frame_cnt wrap.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: default 640x480@60
    logic       d_reset, d_display_on, d_line_start, d_frame_start;
    logic [5:0] d_color;
    logic [9:0] d_pix_x, d_pix_y;
    logic [7:0] d_frame_cnt, d_vga_out;

    // instance 1: 20x10 raster, active-high sync
    logic       s_reset, s_display_on, s_line_start, s_frame_start;
    logic [5:0] s_color;
    logic [9:0] s_pix_x, s_pix_y;
    logic [7:0] s_frame_cnt, s_vga_out;

    vga_timing_gen dut (
        .clk         (clk),
        .reset       (d_reset),
        .color_in    (d_color),
        .pix_x       (d_pix_x),
        .pix_y       (d_pix_y),
        .display_on  (d_display_on),
        .line_start  (d_line_start),
        .frame_start (d_frame_start),
        .frame_cnt   (d_frame_cnt),
        .vga_out     (d_vga_out)
    );

    vga_timing_gen #(
        .H_ACTIVE (12), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL (1'b1)
    ) dut_s (
        .clk         (clk),
        .reset       (s_reset),
        .color_in    (s_color),
        .pix_x       (s_pix_x),
        .pix_y       (s_pix_y),
        .display_on  (s_display_on),
        .line_start  (s_line_start),
        .frame_start (s_frame_start),
        .frame_cnt   (s_frame_cnt),
        .vga_out     (s_vga_out)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    int hact[2] = '{640, 12};
    int hfp[2]  = '{16, 2};
    int hsyn[2] = '{96, 3};
    int hbp[2]  = '{48, 3};
    int vact[2] = '{480, 6};
    int vfp[2]  = '{10, 1};
    int vsyn[2] = '{2, 2};
    int vbp[2]  = '{33, 1};
    bit pol[2]  = '{1'b0, 1'b1};

    int mx[2] = '{0, 0};
    int my[2] = '{0, 0};
    int mf[2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock on instance k and compare every output to the raster model.
    task automatic cycle(input int k);
        int         px, py, ht, vt;
        logic [5:0] c, col;
        bit         rst, hs_on, vs_on, act;
        logic       hs_b, vs_b;
        logic [7:0] exp_vga;
        px  = mx[k];
        py  = my[k];
        c   = (k == 0) ? d_color : s_color;
        rst = (k == 0) ? d_reset : s_reset;
        ht  = hact[k] + hfp[k] + hsyn[k] + hbp[k];
        vt  = vact[k] + vfp[k] + vsyn[k] + vbp[k];
        @(negedge clk);
        if (rst) begin
            mx[k]   = 0;
            my[k]   = 0;
            mf[k]   = 0;
            exp_vga = {~pol[k], 3'b000, ~pol[k], 3'b000};
        end else begin
            hs_on   = (px >= hact[k] + hfp[k]) && (px < hact[k] + hfp[k] + hsyn[k]);
            vs_on   = (py >= vact[k] + vfp[k]) && (py < vact[k] + vfp[k] + vsyn[k]);
            act     = (px < hact[k]) && (py < vact[k]);
            col     = act ? c : 6'b0;
            hs_b    = hs_on ? pol[k] : ~pol[k];
            vs_b    = vs_on ? pol[k] : ~pol[k];
            exp_vga = {hs_b, col[0], col[2], col[4], vs_b, col[1], col[3], col[5]};
            mx[k]++;
            if (mx[k] == ht) begin
                mx[k] = 0;
                my[k]++;
                if (my[k] == vt) begin
                    my[k] = 0;
                    mf[k] = (mf[k] + 1) % 256;
                end
            end
        end
        if (k == 0) begin
            check("pix_x", 32'(d_pix_x), 32'(mx[0]));
            check("pix_y", 32'(d_pix_y), 32'(my[0]));
            check("frame_cnt", 32'(d_frame_cnt), 32'(mf[0]));
            check("display_on", 32'(d_display_on), 32'(mx[0] < hact[0] && my[0] < vact[0]));
            check("line_start", 32'(d_line_start), 32'(mx[0] == 0));
            check("frame_start", 32'(d_frame_start), 32'(mx[0] == 0 && my[0] == 0));
            check("vga_out", 32'(d_vga_out), 32'(exp_vga));
        end else begin
            check("s_pix_x", 32'(s_pix_x), 32'(mx[1]));
            check("s_pix_y", 32'(s_pix_y), 32'(my[1]));
            check("s_frame_cnt", 32'(s_frame_cnt), 32'(mf[1]));
            check("s_display_on", 32'(s_display_on), 32'(mx[1] < hact[1] && my[1] < vact[1]));
            check("s_line_start", 32'(s_line_start), 32'(mx[1] == 0));
            check("s_frame_start", 32'(s_frame_start), 32'(mx[1] == 0 && my[1] == 0));
            check("s_vga_out", 32'(s_vga_out), 32'(exp_vga));
        end
    endtask

    initial begin
        int hs_low, ones, ls_cnt, ls_first, ls_second, vs_act, fs_cnt;
        d_reset = 1'b1;
        s_reset = 1'b1;
        d_color = 6'b0;
        s_color = 6'b0;

        // reset held three clocks, then released
        repeat (3) begin
            cycle(0);
            check("reset_vga_88", 32'(d_vga_out), 32'h88);
        end
        d_reset = 1'b0;
        check("post_reset_x", 32'(d_pix_x), 32'd0);
        check("post_reset_y", 32'(d_pix_y), 32'd0);
        check("post_reset_frame_start", 32'(d_frame_start), 32'd1);
        check("post_reset_display_on", 32'(d_display_on), 32'd1);

        // single colour at pix_x=5
        repeat (5) cycle(0);
        check("at_x5", 32'(d_pix_x), 32'd5);
        d_color = 6'b10_01_11;
        cycle(0);
        check("color_pack_x5", 32'(d_vga_out), 32'hED);

        // two lines of full white: hsync width, colour count, line_start period
        d_color   = 6'h3F;
        hs_low    = 0;
        ones      = 0;
        ls_cnt    = 0;
        ls_first  = -1;
        ls_second = -1;
        for (int i = 0; i < 1600; i++) begin
            cycle(0);
            if (i < 800) begin
                if (d_vga_out[7] == 1'b0) hs_low++;
                if ((d_vga_out & 8'h77) == 8'h77) ones++;
            end
            if (d_line_start) begin
                if (ls_cnt == 0) ls_first = i;
                else if (ls_cnt == 1) ls_second = i;
                ls_cnt++;
            end
        end
        check("hsync_low_clks", 32'(hs_low), 32'd96);
        check("white_clks_per_line", 32'(ones), 32'd640);
        check("line_start_count", 32'(ls_cnt), 32'd2);
        check("line_start_period", 32'(ls_second - ls_first), 32'd800);

        // reset pulsed mid-line at pix_x=300
        while (mx[0] != 300) cycle(0);
        check("pre_reset_y", 32'(d_pix_y), 32'd2);
        d_reset = 1'b1;
        cycle(0);
        d_reset = 1'b0;
        check("midline_reset_x", 32'(d_pix_x), 32'd0);
        check("midline_reset_y", 32'(d_pix_y), 32'd0);
        check("midline_reset_fs", 32'(d_frame_start), 32'd1);
        check("midline_reset_vga", 32'(d_vga_out), 32'h88);
        repeat (10) cycle(0);

        // small raster: default instance parked in reset from here on
        d_reset = 1'b1;
        repeat (2) begin
            cycle(1);
            check("s_reset_vga_00", 32'(s_vga_out), 32'h00);
        end
        s_reset = 1'b0;
        vs_act  = 0;
        fs_cnt  = 0;
        for (int i = 0; i < 200; i++) begin
            s_color = 6'((mx[1] * 5 + my[1] * 3) & 63);
            cycle(1);
            if (s_vga_out[3]) vs_act++;
            if (s_frame_start) fs_cnt++;
        end
        check("s_vsync_clks", 32'(vs_act), 32'd40);
        check("s_frame_start_period", 32'(fs_cnt), 32'd1);
        check("s_frame_cnt_one", 32'(s_frame_cnt), 32'd1);

        // mid-frame reset at x=7, y=4
        while (!(mx[1] == 7 && my[1] == 4)) cycle(1);
        s_reset = 1'b1;
        cycle(1);
        s_reset = 1'b0;
        check("s_midframe_reset_cnt", 32'(s_frame_cnt), 32'd0);
        check("s_midframe_reset_xy", 32'({s_pix_y, s_pix_x}), 32'd0);

        // 256 frames: frame_cnt wraps back to 0
        for (int i = 0; i < 256 * 200; i++) begin
            s_color = 6'((mx[1] ^ (my[1] << 2)) & 63);
            cycle(1);
            if (i == 255 * 200 - 1) check("s_frame_cnt_255", 32'(s_frame_cnt), 32'd255);
        end
        check("s_frame_cnt_wrap", 32'(s_frame_cnt), 32'd0);
        check("s_wrap_xy", 32'({s_pix_y, s_pix_x}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
